fpnew_hub_mult_pipe: RTL and testbench
======================================

// Module: fpnew_hub_mult_pipe
// PURPOSE
//  Pipelined, back-pressurable HUB-format multiplier slice for the FPnew datapath.
//  Wraps the combinational FPHUB_mult core (M/E generics) behind a full FPnew
//  valid/ready interface.
//  Adds a parametrised retiming pipeline, tag/mask sideband, flush, sign-mode
//  (op_mod_i) and a derived status_t.
//  Sits in the FPnew ADDMUL/MUL opgroup slot in place of the single-cycle wrapper.
// PARAMETERS
//  FpFormat     fpnew_pkg::FP32            operand format
//  WIDTH        fp_width(FpFormat)         operand/result width (=E+M+1)
//  M            man_bits(FpFormat)         mantissa bits passed to FPHUB_mult
//  E            exp_bits(FpFormat)         exponent bits passed to FPHUB_mult
//  NumPipeRegs  2                          pipeline stages after core, 0..4
//  TagWidth     4                          width of tag_i/tag_o sideband
// PORTS
//  clk_i        in   1          single clock, all regs rising edge
//  rst_ni       in   1          synchronous, active-low reset
//  operands_i   in   3xWIDTH    [0]=X, [1]=Y, [2] ignored
//  op_i         in   operation_e  only MUL valid; others flagged NV
//  op_mod_i     in   1          1: negate product sign (result sign = ~sign)
//  tag_i        in   TagWidth   opaque tag, returned with result
//  in_valid_i   in   1          request valid
//  in_ready_o   out  1          request accepted when valid&ready
//  flush_i      in   1          drop all in-flight ops
//  result_o     out  WIDTH      HUB product
//  status_o     out  status_t   {NV,DZ,OF,UF,NX}
//  tag_o        out  TagWidth   tag of result_o
//  out_valid_o  out  1          result valid
//  out_ready_i  in   1          downstream ready
//  busy_o       out  1          any stage holds a valid op
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (clk_i, rst_ni).
//    On rst_ni=0 at an edge: all stage valids=0; data regs don't-care.
//    Outputs then: out_valid_o=0, busy_o=0, in_ready_o=1. result_o, status_o,
//    tag_o are 0 because the output mux is gated by valid.
//  - Stage 0 (comb):
//    X, Y -> FPHUB_mult -> Z; if op_mod_i, Z[WIDTH-1] is inverted.
//    Status:
//      mag(v) = v[WIDTH-2:0]; INF = all ones; ZERO = all zeros.
//      NV = (ZERO(X)&INF(Y)) | (INF(X)&ZERO(Y)) | (op_i!=MUL); on NV, result=+INF.
//      OF = INF(Z) & ~INF(X) & ~INF(Y) & ~NV.
//      UF = ZERO(Z) & ~ZERO(X) & ~ZERO(Y).
//      NX = OF|UF; DZ = 0.
//  - Pipeline: NumPipeRegs stages, each {valid,result,status,tag}.
//    Stage i loads from i-1 when ready_i = ~valid_i | ready_{i+1};
//    last stage's ready is out_ready_i.
//    in_ready_o = ready of stage 1; bubbles collapse.
//    Throughput 1 op/cycle when unstalled.
//  - Latency: op accepted at edge t appears at out_valid_o after edge
//    t+NumPipeRegs-1, i.e. NumPipeRegs cycles. With NumPipeRegs=0 the path is
//    fully combinational: in_ready_o=out_ready_i, out_valid_o=in_valid_i.
//  - Capacity: NumPipeRegs ops; a full pipe with out_ready_i=0 drives
//    in_ready_o=0. Outputs are held stable while out_valid_o=1 & out_ready_i=0.
//  - Ordering strictly FIFO; no op lost or duplicated under any stall pattern.
//  - Simultaneous accept+retire on a full pipe is permitted (ready ripples
//    combinationally).
//  - flush_i=1 at an edge: all valids cleared; any input presented that cycle is
//    not captured; in_ready_o is still driven normally. Flush is ignored while
//    rst_ni=0, since reset dominates.
//  - Reset mid-operation: in-flight ops are discarded, same as flush.
//  - busy_o = OR of stage valids.
// TESTING
//  1 FP32, NumPipeRegs=2: X=0x7FFFFFFF, Y=0x3F800000, accepted at t
//    -> out_valid_o at t+2, result 0x7FFFFFFF, all status flags 0 (INF input).
//  2 X=0x00000000, Y=0x7FFFFFFF -> result 0x7FFFFFFF, NV=1, others 0.
//    Same X with op_i=ADD -> NV=1.
//  3 Stream 8 random ops, out_ready_i=0 for cycles 3..7 -> in_ready_o=0 after 2
//    held ops. All 8 results match the FPHUB_mult model in order; tags 0..7.
//  4 op_mod_i=1, X=0x40000000, Y=0xC0000000 -> sign(result)=0, magnitude equals
//    the op_mod_i=0 case.
//  5 3 ops in flight, flush_i pulse -> out_valid_o=0 next cycle, busy_o=0; the
//    next op completes normally. Same stimulus with rst_ni pulse -> same result.
//  6 NumPipeRegs=0: out_valid_o==in_valid_i and in_ready_o==out_ready_i in the
//    same cycle, result is combinational.

Source files
------------

// File: rtl/fpnew_hub_mult_pipe.sv
// Pipelined HUB-format multiplier with valid/ready handshake,
// tag sideband, flush, sign-negate mode and IEEE-style status flags.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   operands_i         [0]=X, [1]=Y, [2] unused
//   op_i               operation code, only MUL (4'd3) is valid
//   op_mod_i           1: invert product sign
//   tag_i / tag_o      opaque tag travelling with the op
//   in_valid_i/in_ready_o    request handshake
//   flush_i            drop all in-flight ops
//   result_o/status_o  product and {NV,DZ,OF,UF,NX}
//   out_valid_o/out_ready_i  response handshake
//   busy_o             any stage holds a valid op
module fpnew_hub_mult_pipe #(
  parameter int M           = 23,
  parameter int E           = 8,
  parameter int WIDTH       = E + M + 1,
  parameter int NumPipeRegs = 2,
  parameter int TagWidth    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2:0][WIDTH-1:0] operands_i,
  input  logic [3:0]            op_i,
  input  logic                  op_mod_i,
  input  logic [TagWidth-1:0]   tag_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      result_o,
  output logic [4:0]            status_o,
  output logic [TagWidth-1:0]   tag_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  localparam int SW = M + 2;
  localparam int PW = 2 * SW;
  localparam logic [E+1:0] BIAS =
    (E+2)'((1 << (E - 1)) - 1);
  localparam logic [3:0] OP_MUL = 4'd3;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-2:0] mag_x;
  logic [WIDTH-2:0] mag_y;
  logic             inf_x;
  logic             inf_y;
  logic             zero_x;
  logic             zero_y;
  logic [SW-1:0]    sig_x;
  logic [SW-1:0]    sig_y;
  logic [PW-1:0]    prod;
  logic             norm;
  logic [E+1:0]     exp_sum;
  logic [M-1:0]     mant;
  logic             sgn;
  logic [WIDTH-2:0] mag_z;
  logic             nv;
  logic             of;
  logic             uf;
  logic [WIDTH-1:0] s0_res;
  logic [4:0]       s0_status;

  assign x = operands_i[0];
  assign y = operands_i[1];

  // HUB operands carry an implicit leading one and an implicit
  // trailing one (ILSB); round-to-nearest is plain truncation.
  always_comb begin
    mag_x  = x[WIDTH-2:0];
    mag_y  = y[WIDTH-2:0];
    inf_x  = &mag_x;
    inf_y  = &mag_y;
    zero_x = ~|mag_x;
    zero_y = ~|mag_y;
    sig_x  = {1'b1, x[M-1:0], 1'b1};
    sig_y  = {1'b1, y[M-1:0], 1'b1};
    prod   = PW'(sig_x) * PW'(sig_y);
    norm   = prod[PW-1];
    // Signed in E+2 bits: MSB set means underflow,
    // bit E set (and non-negative) means overflow.
    exp_sum = {2'b00, x[WIDTH-2:M]}
            + {2'b00, y[WIDTH-2:M]}
            + {{(E+1){1'b0}}, norm}
            - BIAS;
    mant = norm ? prod[PW-2 -: M]
                : prod[PW-3 -: M];
    sgn  = x[WIDTH-1] ^ y[WIDTH-1] ^ op_mod_i;
    if (inf_x | inf_y) begin
      mag_z = '1;
    end else if (zero_x | zero_y) begin
      mag_z = '0;
    end else if (exp_sum[E+1]) begin
      mag_z = '0;
    end else if (exp_sum[E]) begin
      mag_z = '1;
    end else begin
      mag_z = {exp_sum[E-1:0], mant};
    end
    nv = (zero_x & inf_y) | (inf_x & zero_y)
       | (op_i != OP_MUL);
    s0_res = nv ? {1'b0, {(WIDTH-1){1'b1}}}
                : {sgn, mag_z};
    of = (&s0_res[WIDTH-2:0]) & ~inf_x
       & ~inf_y & ~nv;
    uf = (~|s0_res[WIDTH-2:0]) & ~zero_x
       & ~zero_y;
    s0_status = {nv, 1'b0, of, uf, of | uf};
  end

  logic unused_bits;
  assign unused_bits = ^{operands_i[2], prod[M+1:0]};

  if (NumPipeRegs == 0) begin : g_comb

    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign result_o    = in_valid_i ? s0_res : '0;
    assign status_o    = in_valid_i ? s0_status : '0;
    assign tag_o       = in_valid_i ? tag_i : '0;
    assign busy_o      = 1'b0;

    logic unused_ctl;
    assign unused_ctl = ^{clk_i, rst_ni, flush_i};

  end else begin : g_pipe

    localparam int N = NumPipeRegs;

    logic [N-1:0]                valid_q;
    logic [N-1:0]                valid_d;
    logic [N-1:0][WIDTH-1:0]     res_q;
    logic [N-1:0][WIDTH-1:0]     res_d;
    logic [N-1:0][4:0]           st_q;
    logic [N-1:0][4:0]           st_d;
    logic [N-1:0][TagWidth-1:0]  tag_q;
    logic [N-1:0][TagWidth-1:0]  tag_d;
    logic [N-1:0]                ready;
    logic [N-1:0]                up_valid;
    logic [N-1:0][WIDTH-1:0]     up_res;
    logic [N-1:0][4:0]           up_st;
    logic [N-1:0][TagWidth-1:0]  up_tag;

    // Ready ripples back from the sink so a full pipe can
    // accept and retire in the same cycle.
    always_comb begin
      ready[N-1] = ~valid_q[N-1] | out_ready_i;
      for (int i = N - 2; i >= 0; i--) begin
        ready[i] = ~valid_q[i] | ready[i+1];
      end
    end

    always_comb begin
      up_valid[0] = in_valid_i;
      up_res[0]   = s0_res;
      up_st[0]    = s0_status;
      up_tag[0]   = tag_i;
      for (int i = 1; i < N; i++) begin
        up_valid[i] = valid_q[i-1];
        up_res[i]   = res_q[i-1];
        up_st[i]    = st_q[i-1];
        up_tag[i]   = tag_q[i-1];
      end
    end

    always_comb begin
      valid_d = valid_q;
      res_d   = res_q;
      st_d    = st_q;
      tag_d   = tag_q;
      for (int i = 0; i < N; i++) begin
        if (ready[i]) begin
          valid_d[i] = up_valid[i];
          // Data only moves with a valid op so held
          // outputs stay stable.
          if (up_valid[i]) begin
            res_d[i] = up_res[i];
            st_d[i]  = up_st[i];
            tag_d[i] = up_tag[i];
          end
        end
      end
      if (flush_i) begin
        valid_d = '0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q <= '0;
      end else begin
        valid_q <= valid_d;
      end
      res_q <= res_d;
      st_q  <= st_d;
      tag_q <= tag_d;
    end

    assign in_ready_o  = ready[0];
    assign out_valid_o = valid_q[N-1];
    assign result_o    = valid_q[N-1] ? res_q[N-1] : '0;
    assign status_o    = valid_q[N-1] ? st_q[N-1] : '0;
    assign tag_o       = valid_q[N-1] ? tag_q[N-1] : '0;
    assign busy_o      = |valid_q;

  end

endmodule

// File: tb/tb_fpnew_hub_mult_pipe.sv
// Directed bench for fpnew_hub_mult_pipe: latency, NV cases,
// stall/FIFO order, sign mode, flush/reset, combinational mode.
module tb_fpnew_hub_mult_pipe;

  localparam logic [3:0] MUL = 4'd3;
  localparam logic [3:0] ADD = 4'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0][31:0] ops;
  logic [3:0]       op;
  logic             mod;
  logic [3:0]       tag;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [31:0]      result;
  logic [4:0]       status;
  logic [3:0]       tag_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  logic             in_valid0;
  logic             in_ready0;
  logic [31:0]      result0;
  logic [4:0]       status0;
  logic [3:0]       tag_out0;
  logic             out_valid0;
  logic             out_ready0;
  logic             busy0;

  int checks = 0;
  int errors = 0;

  fpnew_hub_mult_pipe #(.NumPipeRegs(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(ops),
    .op_i(op), .op_mod_i(mod), .tag_i(tag),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .result_o(result),
    .status_o(status), .tag_o(tag_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy)
  );

  fpnew_hub_mult_pipe #(.NumPipeRegs(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(ops),
    .op_i(op), .op_mod_i(mod), .tag_i(tag),
    .in_valid_i(in_valid0), .in_ready_o(in_ready0),
    .flush_i(1'b0), .result_o(result0),
    .status_o(status0), .tag_o(tag_out0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0),
    .busy_o(busy0)
  );

  task automatic drive(input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [3:0] o,
                       input logic m,
                       input logic [3:0] t,
                       input logic v);
    ops[0]   = x;
    ops[1]   = y;
    ops[2]   = 32'hDEADBEEF;
    op       = o;
    mod      = m;
    tag      = t;
    in_valid = v;
  endtask

  // Presents two ops back to back and collects up to two
  // results with out_ready held high.
  task automatic send_pair(
    input logic [31:0] xa, input logic [31:0] ya,
    input logic [3:0] oa, input logic ma,
    input logic [3:0] ta,
    input logic [31:0] xb, input logic [31:0] yb,
    input logic [3:0] ob, input logic mb,
    input logic [3:0] tb,
    output logic [31:0] r0, output logic [4:0] s0,
    output logic [3:0] g0,
    output logic [31:0] r1, output logic [4:0] s1,
    output logic [3:0] g1, output int n);
    n  = 0;
    r0 = '0; s0 = '0; g0 = '0;
    r1 = '0; s1 = '0; g1 = '0;
    for (int c = 0; c < 12 && n < 2; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (c == 0) drive(xa, ya, oa, ma, ta, 1'b1);
      else if (c == 1) drive(xb, yb, ob, mb, tb, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (n == 0) begin
          r0 = result; s0 = status; g0 = tag_out;
        end else begin
          r1 = result; s1 = status; g1 = tag_out;
        end
        n++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    drive('0, '0, MUL, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got v=%b b=%b want 0 0",
               out_valid, busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (result !== 32'h0 || status !== 5'h0 ||
        tag_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h %b %h want 0 0 0",
               result, status, tag_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(32'h7FFFFFFF, 32'h3F800000, MUL, 1'b0, 4'd3, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_stage1 got v=%b b=%b want 0 1",
               out_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat_out_valid got %b want 1", out_valid);
    end
    checks++;
    if (result !== 32'h7FFFFFFF || status !== 5'b00000 ||
        tag_out !== 4'd3) begin
      errors++;
      $display("FAIL lat_result got %h %b %h want 7fffffff 00000 3",
               result, status, tag_out);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lat_drain got v=%b b=%b want 0 0",
               out_valid, busy);
    end
  endtask

  task automatic test_nv();
    logic [31:0] r0, r1;
    logic [4:0]  s0, s1;
    logic [3:0]  g0, g1;
    int n;
    send_pair(32'h0, 32'h7FFFFFFF, MUL, 1'b0, 4'd1,
              32'h0, 32'h3F800000, ADD, 1'b0, 4'd2,
              r0, s0, g0, r1, s1, g1, n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL nv_count got %0d want 2", n);
    end
    checks++;
    if (r0 !== 32'h7FFFFFFF || s0 !== 5'b10000 ||
        g0 !== 4'd1) begin
      errors++;
      $display("FAIL nv_zero_inf got %h %b %h want 7fffffff 10000 1",
               r0, s0, g0);
    end
    checks++;
    if (r1 !== 32'h7FFFFFFF || s1 !== 5'b10000 ||
        g1 !== 4'd2) begin
      errors++;
      $display("FAIL nv_bad_op got %h %b %h want 7fffffff 10000 2",
               r1, s1, g1);
    end
  endtask

  task automatic test_op_mod();
    logic [31:0] r0, r1;
    logic [4:0]  s0, s1;
    logic [3:0]  g0, g1;
    int n;
    send_pair(32'h40000000, 32'hC0000000, MUL, 1'b1, 4'd4,
              32'h40000000, 32'hC0000000, MUL, 1'b0, 4'd5,
              r0, s0, g0, r1, s1, g1, n);
    checks++;
    if (n !== 2 || r0 !== 32'h40800001 || s0 !== 5'b0) begin
      errors++;
      $display("FAIL opmod_neg got n=%0d %h %b want 2 40800001 00000",
               n, r0, s0);
    end
    checks++;
    if (r1 !== 32'hC0800001 || s1 !== 5'b0) begin
      errors++;
      $display("FAIL opmod_plain got %h %b want c0800001 00000",
               r1, s1);
    end
    checks++;
    if (r0[31] !== 1'b0 || r0[30:0] !== r1[30:0]) begin
      errors++;
      $display("FAIL opmod_mag got %h vs %h want sign 0 same mag",
               r0, r1);
    end
  endtask

  task automatic test_stall();
    logic [31:0] xs[8];
    logic [31:0] ys[8];
    logic [31:0] er[8];
    logic [4:0]  es[8];
    int  pi;
    int  ci;
    bit  acc;
    xs[0] = 32'h3F800000; ys[0] = 32'h3F800000;
    er[0] = 32'h3F800001; es[0] = 5'b00000;
    xs[1] = 32'h40000000; ys[1] = 32'h3F800000;
    er[1] = 32'h40000001; es[1] = 5'b00000;
    xs[2] = 32'h40400000; ys[2] = 32'h3F800000;
    er[2] = 32'h40400001; es[2] = 5'b00000;
    xs[3] = 32'h3FC00000; ys[3] = 32'h3FC00000;
    er[3] = 32'h40100000; es[3] = 5'b00000;
    xs[4] = 32'h7F000000; ys[4] = 32'h7F000000;
    er[4] = 32'h7FFFFFFF; es[4] = 5'b00101;
    xs[5] = 32'h00800000; ys[5] = 32'h00800000;
    er[5] = 32'h00000000; es[5] = 5'b00011;
    xs[6] = 32'hBF800000; ys[6] = 32'h3F800000;
    er[6] = 32'hBF800001; es[6] = 5'b00000;
    xs[7] = 32'h40000000; ys[7] = 32'h40000000;
    er[7] = 32'h40800001; es[7] = 5'b00000;
    pi = 0;
    ci = 0;
    for (int cyc = 0; cyc < 60 && ci < 8; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 7);
      if (pi < 8) drive(xs[pi], ys[pi], MUL, 1'b0, 4'(pi), 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (cyc == 7) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || result !== er[1] ||
            tag_out !== 4'd1) begin
          errors++;
          $display("FAIL stall_hold got v=%b %h tag %h want 1 %h 1",
                   out_valid, result, tag_out, er[1]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (result !== er[ci] || status !== es[ci] ||
            tag_out !== 4'(ci)) begin
          errors++;
          $display("FAIL stall_res%0d got %h %b %h want %h %b %h",
                   ci, result, status, tag_out,
                   er[ci], es[ci], 4'(ci));
        end
        ci++;
      end
      if (acc) pi++;
    end
    checks++;
    if (ci !== 8) begin
      errors++;
      $display("FAIL stall_count got %0d want 8", ci);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_flush(input bit use_rst);
    int n;
    logic [31:0] r;
    logic [3:0]  g;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(32'h3F800000, 32'h3F800000, MUL, 1'b0, 4'd8, 1'b1);
    @(posedge clk); #1;
    drive(32'h40000000, 32'h3F800000, MUL, 1'b0, 4'd9, 1'b1);
    @(posedge clk); #1;
    drive(32'h40400000, 32'h3F800000, MUL, 1'b0, 4'd10, 1'b1);
    if (use_rst) rst_n = 1'b0;
    else flush = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_full rst=%0b got r=%b b=%b want 0 1",
               use_rst, in_ready, busy);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear rst=%0b got v=%b b=%b r=%b want 0 0 1",
               use_rst, out_valid, busy, in_ready);
    end
    n = 0;
    r = '0;
    g = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 0)
        drive(32'h40000000, 32'h3F800000, MUL, 1'b0, 4'd6, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        r = result;
        g = tag_out;
        n++;
      end
    end
    checks++;
    if (n !== 1 || r !== 32'h40000001 || g !== 4'd6) begin
      errors++;
      $display("FAIL flush_next rst=%0b got n=%0d %h %h want 1 40000001 6",
               use_rst, n, r, g);
    end
  endtask

  task automatic test_comb();
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive(32'h3F800000, 32'h3F800000, MUL, 1'b0, 4'd7, 1'b0);
    in_valid0 = 1'b1;
    out_ready0 = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL comb_hs1 got v=%b r=%b want 1 0",
               out_valid0, in_ready0);
    end
    checks++;
    if (result0 !== 32'h3F800001 || tag_out0 !== 4'd7 ||
        status0 !== 5'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL comb_res1 got %h %h %b %b want 3f800001 7 00000 0",
               result0, tag_out0, status0, busy0);
    end
    ops[0] = 32'h40000000;
    ops[1] = 32'h40000000;
    #1;
    checks++;
    if (result0 !== 32'h40800001) begin
      errors++;
      $display("FAIL comb_res2 got %h want 40800001", result0);
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 ||
        result0 !== 32'h0) begin
      errors++;
      $display("FAIL comb_idle got v=%b r=%b %h want 0 1 0",
               out_valid0, in_ready0, result0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_nv();
    test_op_mod();
    test_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    test_comb();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
